// File: rtl/trigseq_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
package trigseq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_e;

  // Per-bit trig_type encoding.
  localparam logic TYPE_LEVEL = 1'b0;
  localparam logic TYPE_EDGE  = 1'b1;

  // Zero-valued sizes/counts behave as one.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  // Unsigned upper clamp.
  function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// Combinational match of one sample against one trigger stage.
// Each masked bit must satisfy its level or edge condition; unmasked bits
// are don't-care, so an all-zero mask matches every sample.
module trigger_stage_match
  import trigseq_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] cur_i,
  input  logic [SIZE-1:0] prev_i,
  input  logic            prev_vld_i,
  input  logic [SIZE-1:0] mask_i,
  input  logic [SIZE-1:0] type_i,
  input  logic [SIZE-1:0] level_i,
  output logic            match_o
);

  logic [SIZE-1:0] term;

  // Per-bit condition; edge terms need a valid previous sample.
  always_comb begin
    term = '0;
    for (int b = 0; b < SIZE; b++) begin
      if (type_i[b] == TYPE_EDGE)
        term[b] = prev_vld_i && (prev_i[b] != level_i[b]) && (cur_i[b] == level_i[b]);
      else
        term[b] = (cur_i[b] == level_i[b]);
    end
  end

  assign match_o = &(~mask_i | term);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger and capture sequencer for the logic analyser.
// Walks num_levels stages in order, then fills the post-trigger part of a
// circular sample buffer, driving write address/strobe and trigger_pos.
// Optional feature macro: TRIGSEQ_EXT_TRIG_EN adds ext_trig_i, which forces
// an immediate trigger on a strobed sample in WAIT.
module trigger_sequencer
  import trigseq_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int LEVELS  = 8,
  parameter int SADDR_W = 24,
  parameter int CNT_W   = 16,
  localparam int NL_W   = $clog2(LEVELS + 1),
  localparam int STG_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      sample_en_i,
  input  logic [SIZE-1:0]           dinput_i,
  input  logic                      arm_i,
  input  logic                      abort_i,
`ifdef TRIGSEQ_EXT_TRIG_EN
  input  logic                      ext_trig_i,
`endif
  input  logic [NL_W-1:0]           num_levels_i,
  input  logic [LEVELS*SIZE-1:0]    trig_mask_i,
  input  logic [LEVELS*SIZE-1:0]    trig_type_i,
  input  logic [LEVELS*SIZE-1:0]    trig_level_i,
  input  logic [LEVELS*CNT_W-1:0]   trig_count_i,
  input  logic [SADDR_W-1:0]        post_trigger_count_i,
  input  logic [SADDR_W-1:0]        buffer_size_i,
  output logic [SADDR_W-1:0]        wr_addr_o,
  output logic                      wr_en_o,
  output logic [STG_W-1:0]          stage_o,
  output logic                      armed_o,
  output logic                      triggered_o,
  output logic                      done_o,
  output logic                      ready_o,
  output logic [SADDR_W-1:0]        trigger_pos_o
);

  state_e               state_q, state_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SADDR_W-1:0]   pre_q, pre_d, post_q, post_d;
  logic [SADDR_W-1:0]   ptr_q, ptr_d, wr_addr_q, wr_addr_d, tpos_q, tpos_d;
  logic                 wr_en_q, wr_en_d, trig_q, trig_d, pvld_q, pvld_d;
  logic [SIZE-1:0]      prev_q, prev_d;

  logic [SIZE-1:0]      cur_mask, cur_type, cur_level;
  logic [CNT_W-1:0]     cur_cnt;
  logic [31:0]          buf32, post32, pre32, nl32, cnt32;
  logic                 match, cnt_hit, last_stage, ext_fire, fire, capturing;

`ifdef TRIGSEQ_EXT_TRIG_EN
  assign ext_fire = ext_trig_i;
`else
  assign ext_fire = 1'b0;
`endif

  // Active stage configuration and clamped targets, all compared at 32 bits.
  always_comb begin
    cur_mask   = trig_mask_i [32'(stage_q)*SIZE  +: SIZE];
    cur_type   = trig_type_i [32'(stage_q)*SIZE  +: SIZE];
    cur_level  = trig_level_i[32'(stage_q)*SIZE  +: SIZE];
    cur_cnt    = trig_count_i[32'(stage_q)*CNT_W +: CNT_W];
    buf32      = at_least_one(32'(buffer_size_i));
    post32     = clamp_max(32'(post_trigger_count_i), buf32 - 32'd1);
    pre32      = buf32 - post32;
    nl32       = clamp_max(32'(num_levels_i), 32'(LEVELS));
    cnt32      = at_least_one(32'(cur_cnt));
    cnt_hit    = (32'(cnt_q) + 32'd1) >= cnt32;
    last_stage = (32'(stage_q) + 32'd1) >= nl32;
  end

  trigger_stage_match #(.SIZE(SIZE)) u_match (
    .cur_i      (dinput_i),
    .prev_i     (prev_q),
    .prev_vld_i (pvld_q),
    .mask_i     (cur_mask),
    .type_i     (cur_type),
    .level_i    (cur_level),
    .match_o    (match)
  );

  assign fire      = ext_fire || (nl32 == 32'd0) || (match && cnt_hit && last_stage);
  assign capturing = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);

  // Next-state: FSM, stage/occurrence counters, fill counters, write pointer.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    post_d    = post_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    tpos_d    = tpos_q;
    trig_d    = trig_q;
    prev_d    = prev_q;
    pvld_d    = pvld_q;
    if (abort_i) begin
      // Cancel wins over everything, including a same-cycle arm or sample.
      state_d = IDLE;
      pvld_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_i) begin
            state_d = PRE;
            stage_d = '0;
            cnt_d   = '0;
            pre_d   = '0;
            post_d  = '0;
            trig_d  = 1'b0;
            pvld_d  = 1'b0;
          end
        end
        PRE: begin
          if (sample_en_i) begin
            pre_d = pre_q + 1'b1;
            if (32'(pre_q) + 32'd1 >= pre32) state_d = WAIT;
          end
        end
        WAIT: begin
          if (sample_en_i) begin
            prev_d = dinput_i;
            pvld_d = 1'b1;
            if (fire) begin
              state_d = POST;
              trig_d  = 1'b1;
              tpos_d  = ptr_q;
              post_d  = '0;
              cnt_d   = '0;
            end else if (match) begin
              if (cnt_hit) begin
                stage_d = stage_q + 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        POST: begin
          // A zero target completes on the cycle after the trigger.
          if (32'(post_q) >= post32) begin
            state_d = DONE;
          end else if (sample_en_i) begin
            post_d = post_q + 1'b1;
            if (32'(post_q) + 32'd1 >= post32) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (sample_en_i && capturing) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        ptr_d     = (32'(ptr_q) + 32'd1 >= buf32) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      tpos_q    <= '0;
      trig_q    <= 1'b0;
      prev_q    <= '0;
      pvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      tpos_q    <= tpos_d;
      trig_q    <= trig_d;
      prev_q    <= prev_d;
      pvld_q    <= pvld_d;
    end
  end

  assign wr_addr_o     = wr_addr_q;
  assign wr_en_o       = wr_en_q;
  assign stage_o       = stage_q;
  assign armed_o       = (state_q == PRE) || (state_q == WAIT);
  assign triggered_o   = trig_q;
  assign done_o        = (state_q == DONE);
  assign ready_o       = (state_q == IDLE) || (state_q == DONE);
  assign trigger_pos_o = tpos_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: write addresses are checked through
// a scoreboard queue filled as samples are driven; status checked inline.
module tb_trigger_sequencer;
  localparam int SIZE = 32, LEVELS = 8, SADDR_W = 24, CNT_W = 16;
  localparam int NL_W = $clog2(LEVELS + 1);
  localparam int STG_W = $clog2(LEVELS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_en = 1'b0, arm = 1'b0, abort = 1'b0, ext_trig = 1'b0;
  logic [SIZE-1:0] dinput = '0;
  logic [NL_W-1:0] num_levels = '0;
  logic [LEVELS*SIZE-1:0] trig_mask = '0, trig_type = '0, trig_level = '0;
  logic [LEVELS*CNT_W-1:0] trig_count = '0;
  logic [SADDR_W-1:0] post_cnt = '0, buf_size = '0;
  logic [SADDR_W-1:0] wr_addr, trigger_pos;
  logic wr_en, armed, triggered, done, ready;
  logic [STG_W-1:0] stage;

  int total = 0, bad = 0;
  int exp_q[$];
  int mptr = 0, mbuf = 1;
  bit cap = 0;
  int exp_addr;

  trigger_sequencer #(.SIZE(SIZE), .LEVELS(LEVELS), .SADDR_W(SADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .sample_en_i(sample_en), .dinput_i(dinput),
    .arm_i(arm), .abort_i(abort),
`ifdef TRIGSEQ_EXT_TRIG_EN
    .ext_trig_i(ext_trig),
`endif
    .num_levels_i(num_levels), .trig_mask_i(trig_mask), .trig_type_i(trig_type),
    .trig_level_i(trig_level), .trig_count_i(trig_count),
    .post_trigger_count_i(post_cnt), .buffer_size_i(buf_size),
    .wr_addr_o(wr_addr), .wr_en_o(wr_en), .stage_o(stage), .armed_o(armed),
    .triggered_o(triggered), .done_o(done), .ready_o(ready), .trigger_pos_o(trigger_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next expected address.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL wr_unexpected observed=%0d expected=no_write", wr_addr);
      end
      if (exp_q.size() > 0) begin
        exp_addr = exp_q.pop_front();
        total++;
        assert (wr_addr === SADDR_W'(exp_addr)) else begin
          bad++;
          $error("FAIL wr_addr observed=%0d expected=%0d", wr_addr, exp_addr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [31:0] d);
    sample_en = 1'b1;
    dinput = d;
    if (cap) begin
      exp_q.push_back(mptr);
      mptr = (mptr + 1 >= mbuf) ? 0 : mptr + 1;
    end
    step();
    sample_en = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    cap = 1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    cap = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    mptr = 0;
    cap = 0;
    step();
  endtask

  task automatic set_cfg(input int b, input int p, input int nl);
    buf_size = SADDR_W'(b);
    post_cnt = SADDR_W'(p);
    num_levels = NL_W'(nl);
    mbuf = (b == 0) ? 1 : b;
  endtask

  task automatic set_stage(input int k, input logic [31:0] m, input logic [31:0] t,
                           input logic [31:0] l, input int c);
    trig_mask[k*SIZE +: SIZE] = m;
    trig_type[k*SIZE +: SIZE] = t;
    trig_level[k*SIZE +: SIZE] = l;
    trig_count[k*CNT_W +: CNT_W] = CNT_W'(c);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_wr_addr"}, 64'(wr_addr), 0);
    chk({pfx, "_wr_en"}, 64'(wr_en), 0);
    chk({pfx, "_stage"}, 64'(stage), 0);
    chk({pfx, "_armed"}, 64'(armed), 0);
    chk({pfx, "_triggered"}, 64'(triggered), 0);
    chk({pfx, "_done"}, 64'(done), 0);
    chk({pfx, "_ready"}, 64'(ready), 1);
    chk({pfx, "_trigger_pos"}, 64'(trigger_pos), 0);
  endtask

  initial begin
    // Reset state
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // 1: single level stage, wrap 127 -> 0
    set_cfg(128, 64, 1);
    set_stage(0, 32'h1, 32'h0, 32'h1, 1);
    do_arm();
    chk("t1_armed", 64'(armed), 1);
    chk("t1_ready", 64'(ready), 0);
    repeat (70) smp(32'h0);
    chk("t1_pre_trig", 64'(triggered), 0);
    smp(32'h1);
    chk("t1_trigger_pos", 64'(trigger_pos), 70);
    chk("t1_triggered", 64'(triggered), 1);
    chk("t1_armed_post", 64'(armed), 0);
    repeat (63) smp(32'h0);
    chk("t1_done_early", 64'(done), 0);
    smp(32'h0);
    cap = 0;
    chk("t1_done", 64'(done), 1);
    chk("t1_ready_done", 64'(ready), 1);
    chk("t1_last_addr", 64'(wr_addr), 6);
    smp(32'h0);
    chk("t1_no_wr_done", 64'(wr_en), 0);

    // 2: three edge stages, out-of-order edges ignored
    do_reset();
    set_cfg(16, 4, 3);
    set_stage(0, 32'h1, 32'h1, 32'h1, 2);
    set_stage(1, 32'h2, 32'h2, 32'h0, 1);
    set_stage(2, 32'h4, 32'h4, 32'h4, 1);
    do_arm();
    repeat (12) smp(32'h0);
    smp(32'h1);
    smp(32'h0);
    smp(32'h1);
    chk("t2_stage_first_edge", 64'(stage), 0);
    smp(32'h1);
    smp(32'h4);
    chk("t2_stage_ooo", 64'(stage), 0);
    smp(32'h5);
    chk("t2_stage1", 64'(stage), 1);
    smp(32'h7);
    chk("t2_stage1_hold", 64'(stage), 1);
    smp(32'h4);
    chk("t2_stage2", 64'(stage), 2);
    smp(32'h4);
    smp(32'h0);
    chk("t2_not_trig", 64'(triggered), 0);
    smp(32'h4);
    chk("t2_triggered", 64'(triggered), 1);
    chk("t2_trigger_pos", 64'(trigger_pos), 6);
    repeat (4) smp(32'h0);
    cap = 0;
    chk("t2_done", 64'(done), 1);

    // 3: abort in POST, re-arm continues address, arm+abort stays idle
    do_reset();
    set_cfg(16, 4, 1);
    set_stage(0, 32'h1, 32'h0, 32'h1, 1);
    do_arm();
    repeat (12) smp(32'h0);
    smp(32'h1);
    chk("t3_trigger_pos", 64'(trigger_pos), 12);
    smp(32'h0);
    smp(32'h0);
    do_abort();
    chk("t3_abort_ready", 64'(ready), 1);
    chk("t3_abort_done", 64'(done), 0);
    chk("t3_abort_armed", 64'(armed), 0);
    chk("t3_abort_trig_kept", 64'(triggered), 1);
    smp(32'h1);
    chk("t3_idle_no_wr", 64'(wr_en), 0);
    do_arm();
    chk("t3_rearm_armed", 64'(armed), 1);
    chk("t3_rearm_trig_clr", 64'(triggered), 0);
    smp(32'h0);
    chk("t3_addr_continue", 64'(wr_addr), 15);
    do_abort();
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    chk("t3_armabort_armed", 64'(armed), 0);
    chk("t3_armabort_ready", 64'(ready), 1);

    // 4a: num_levels=0 triggers on the first WAIT sample
    do_reset();
    set_cfg(8, 2, 0);
    do_arm();
    repeat (6) smp(32'h0);
    chk("t4a_armed_wait", 64'(armed), 1);
    smp(32'hdead);
    chk("t4a_triggered", 64'(triggered), 1);
    chk("t4a_trigger_pos", 64'(trigger_pos), 6);
    smp(32'h0);
    chk("t4a_done_early", 64'(done), 0);
    smp(32'h0);
    cap = 0;
    chk("t4a_done", 64'(done), 1);

    // 4b: post=200 with buffer=128 clamps to 127
    do_reset();
    set_cfg(128, 200, 0);
    do_arm();
    smp(32'h0);
    chk("t4b_armed_wait", 64'(armed), 1);
    smp(32'h0);
    chk("t4b_trigger_pos", 64'(trigger_pos), 1);
    repeat (126) smp(32'h0);
    chk("t4b_done_early", 64'(done), 0);
    smp(32'h0);
    cap = 0;
    chk("t4b_done", 64'(done), 1);

    // 4c: trig_count=0 behaves as 1
    do_reset();
    set_cfg(4, 1, 1);
    set_stage(0, 32'h1, 32'h0, 32'h1, 0);
    do_arm();
    repeat (5) smp(32'h0);
    chk("t4c_not_trig", 64'(triggered), 0);
    smp(32'h1);
    chk("t4c_triggered", 64'(triggered), 1);
    chk("t4c_trigger_pos", 64'(trigger_pos), 1);
    smp(32'h0);
    cap = 0;
    chk("t4c_done", 64'(done), 1);

    // 4d: asynchronous reset mid-WAIT
    set_cfg(8, 2, 2);
    set_stage(0, 32'h1, 32'h0, 32'h1, 1);
    set_stage(1, 32'h2, 32'h0, 32'h2, 1);
    do_arm();
    repeat (6) smp(32'h0);
    smp(32'h1);
    chk("t4d_stage1", 64'(stage), 1);
    chk("t4d_wr_en", 64'(wr_en), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("t4d_async");
    exp_q.delete();
    step();
    reset = 1'b0;
    mptr = 0;
    cap = 0;
    step();

    // 5: sparse strobes, one in four cycles
    do_reset();
    set_cfg(8, 2, 0);
    do_arm();
    repeat (6) begin
      smp(32'h0);
      repeat (3) step();
    end
    chk("t5_not_trig", 64'(triggered), 0);
    chk("t5_idle_no_wr", 64'(wr_en), 0);
    smp(32'h0);
    chk("t5_trigger_pos", 64'(trigger_pos), 6);
    repeat (3) step();
    smp(32'h0);
    repeat (3) step();
    chk("t5_done_early", 64'(done), 0);
    smp(32'h0);
    cap = 0;
    chk("t5_done", 64'(done), 1);

`ifdef TRIGSEQ_EXT_TRIG_EN
    // 6: external trigger forces trigger in WAIT, ignored in PRE
    do_reset();
    set_cfg(8, 2, 3);
    set_stage(0, 32'h1, 32'h0, 32'h1, 1);
    set_stage(1, 32'h2, 32'h0, 32'h2, 1);
    set_stage(2, 32'h4, 32'h0, 32'h4, 1);
    do_arm();
    ext_trig = 1'b1;
    smp(32'h0);
    ext_trig = 1'b0;
    chk("t6_pre_ignored", 64'(triggered), 0);
    repeat (5) smp(32'h0);
    smp(32'h1);
    chk("t6_stage1", 64'(stage), 1);
    ext_trig = 1'b1;
    smp(32'h0);
    ext_trig = 1'b0;
    chk("t6_triggered", 64'(triggered), 1);
    chk("t6_trigger_pos", 64'(trigger_pos), 7);
    repeat (2) smp(32'h0);
    cap = 0;
    chk("t6_done", 64'(done), 1);
`endif

    step();
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
